// File: rtl/assert_fail_capture_if.sv
// assert_fail_capture_if
// Bundles the monitoring inputs and capture-record outputs of
// assert_fail_capture so the design and the host side share one port.
//   en, stop_in, ucf_in, host_ack          : host/source -> capture block
//   failure_o, halt_req, fail_src,
//   fail_time, fail_count, fail_ovf,
//   cycle_cnt                              : capture block -> host
// modport slave is the capture block; modport master is the host/sources.
interface assert_fail_capture_if #(
    parameter int TS_W  = 32,
    parameter int CNT_W = 8
);
    logic             en;
    logic             stop_in;
    logic             ucf_in;
    logic             host_ack;
    logic             failure_o;
    logic             halt_req;
    logic [1:0]       fail_src;
    logic [TS_W-1:0]  fail_time;
    logic [CNT_W-1:0] fail_count;
    logic             fail_ovf;
    logic [TS_W-1:0]  cycle_cnt;

    modport slave (
        input  en, stop_in, ucf_in, host_ack,
        output failure_o, halt_req, fail_src, fail_time, fail_count,
               fail_ovf, cycle_cnt
    );

    modport master (
        output en, stop_in, ucf_in, host_ack,
        input  failure_o, halt_req, fail_src, fail_time, fail_count,
               fail_ovf, cycle_cnt
    );
endinterface

// File: rtl/assert_fail_capture.sv
// assert_fail_capture
// Registers and edge-detects the stop / ucf assertion sources feeding the
// emulation FAILURE net, timestamps and records the first failure, counts
// every failure (saturating) and raises halt_req until the host acks.
// After an ack the block waits for both sources to go quiet before
// re-arming, so a still-asserted source cannot retrigger a capture.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : assert_fail_capture_if.slave (see interface header)
module assert_fail_capture #(
    parameter int TS_W  = 32,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    assert_fail_capture_if.slave  bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, HOLD = 2'd1, DRAIN = 2'd2} state_t;

    state_t           state_q, state_d;
    logic             stop_q, stop_qq, ucf_q, ucf_qq;
    logic [TS_W-1:0]  cycle_q, cycle_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       src_q, src_d;
    logic [TS_W-1:0]  time_q, time_d;
    logic             ovf_q, ovf_d;

    logic [1:0] edge_w;
    logic       ev;
    logic       active;
    logic       capture;
    logic       ovf_set;
    logic       halt;

    assign edge_w = {ucf_q & ~ucf_qq, stop_q & ~stop_qq};
    assign ev     = bus.en & (|edge_w);
    assign active = stop_q | ucf_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (ev) state_d = HOLD;
            HOLD:    if (bus.host_ack) state_d = active ? DRAIN : IDLE;
            // With en low the FSM is frozen, so draining waits for en too.
            DRAIN:   if (bus.en && !active) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        capture = (state_q == IDLE) && ev;
        ovf_set = (state_q != IDLE) && ev;
        halt    = (state_q == HOLD);
    end

    // Datapath next-state
    always_comb begin
        cycle_d = bus.en ? cycle_q + 1'b1 : cycle_q;
        cnt_d   = (ev && cnt_q != {CNT_W{1'b1}}) ? cnt_q + 1'b1 : cnt_q;
        src_d   = src_q;
        time_d  = time_q;
        ovf_d   = ovf_q;
        if (capture) begin
            src_d  = edge_w;
            time_d = cycle_q;
            ovf_d  = 1'b0;
        end else if (ovf_set) begin
            ovf_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stop_q  <= 1'b0;
            stop_qq <= 1'b0;
            ucf_q   <= 1'b0;
            ucf_qq  <= 1'b0;
            cycle_q <= '0;
            cnt_q   <= '0;
            src_q   <= '0;
            time_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            // Sampling flops run regardless of en, so edges during en=0 are lost.
            stop_q  <= bus.stop_in;
            stop_qq <= stop_q;
            ucf_q   <= bus.ucf_in;
            ucf_qq  <= ucf_q;
            cycle_q <= cycle_d;
            cnt_q   <= cnt_d;
            src_q   <= src_d;
            time_q  <= time_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.failure_o  = active;
    assign bus.halt_req   = halt;
    assign bus.fail_src   = src_q;
    assign bus.fail_time  = time_q;
    assign bus.fail_count = cnt_q;
    assign bus.fail_ovf   = ovf_q;
    assign bus.cycle_cnt  = cycle_q;
endmodule

// File: tb/tb_assert_fail_capture.sv
module tb_assert_fail_capture;
    localparam int TS_W    = 4;
    localparam int CNT_W   = 8;
    localparam int TS_MOD  = 1 << TS_W;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic             fo;
        logic             halt;
        logic [1:0]       src;
        logic [TS_W-1:0]  tim;
        logic [CNT_W-1:0] cnt;
        logic             ovf;
        logic [TS_W-1:0]  cyc;
    } obs_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    assert_fail_capture_if #(.TS_W(TS_W), .CNT_W(CNT_W)) bus ();
    assert_fail_capture #(.TS_W(TS_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    obs_t expq[$];
    int n_cmp = 0;
    int n_bad = 0;
    int n_pushed = 0;

    // Reference model: the recorded failure, the host-visible mode and the
    // last two samples of each source.
    int mode = 0;               // 0 armed, 1 halted waiting ack, 2 waiting quiet
    int m_cyc = 0, m_cnt = 0, m_tim = 0, m_src = 0;
    bit m_ovf = 0;
    bit s1 = 0, s2 = 0, u1 = 0, u2 = 0;

    task automatic drive(input bit r, input bit e, input bit s, input bit u, input bit a);
        obs_t x;
        bit rs, ru, ev;
        rst = r; bus.en = e; bus.stop_in = s; bus.ucf_in = u; bus.host_ack = a;
        if (r) begin
            mode = 0; m_cyc = 0; m_cnt = 0; m_tim = 0; m_src = 0; m_ovf = 0;
            s1 = 0; s2 = 0; u1 = 0; u2 = 0;
        end else begin
            rs = s1 && !s2;
            ru = u1 && !u2;
            ev = e && (rs || ru);
            if (ev && m_cnt < CNT_MAX) m_cnt++;
            if (mode == 0) begin
                if (ev) begin
                    mode = 1; m_src = {30'd0, ru, rs}; m_tim = m_cyc; m_ovf = 0;
                end
            end else if (mode == 1) begin
                if (ev) m_ovf = 1;
                if (a) mode = (s1 || u1) ? 2 : 0;
            end else begin
                if (ev) m_ovf = 1;
                if (e && !s1 && !u1) mode = 0;
            end
            if (e) m_cyc = (m_cyc + 1) % TS_MOD;
            s2 = s1; s1 = s; u2 = u1; u1 = u;
        end
        x.fo   = s1 || u1;
        x.halt = (mode == 1);
        x.src  = m_src[1:0];
        x.tim  = m_tim[TS_W-1:0];
        x.cnt  = m_cnt[CNT_W-1:0];
        x.ovf  = m_ovf;
        x.cyc  = m_cyc[TS_W-1:0];
        expq.push_back(x);
        n_pushed++;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Monitor: outputs are meaningful every cycle, one expectation per edge.
    initial begin
        obs_t e, g;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                g = {bus.failure_o, bus.halt_req, bus.fail_src, bus.fail_time,
                     bus.fail_count, bus.fail_ovf, bus.cycle_cnt};
                n_cmp++;
                if (g !== e) begin
                    n_bad++;
                    $display("FAIL outputs@%0t got fo=%b halt=%b src=%b tim=%0d cnt=%0d ovf=%b cyc=%0d exp fo=%b halt=%b src=%b tim=%0d cnt=%0d ovf=%b cyc=%0d",
                             $time, g.fo, g.halt, g.src, g.tim, g.cnt, g.ovf, g.cyc,
                             e.fo, e.halt, e.src, e.tim, e.cnt, e.ovf, e.cyc);
                end
            end
        end
    end

    initial begin
        bit s, u;
        bus.en = 0; bus.stop_in = 0; bus.ucf_in = 0; bus.host_ack = 0;
        @(negedge clk);
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        // First capture: stop edge, then ucf edge in HOLD, ack while stop high.
        for (int i = 0; i < 4; i++) drive(0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) drive(0, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 1, 1, 1, 0);
        drive(0, 1, 1, 1, 1);
        for (int i = 0; i < 2; i++) drive(0, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 1, 1, 0, 0);
        drive(0, 1, 0, 0, 1);
        for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, 0);
        // Simultaneous sources: one count, src=11.
        for (int i = 0; i < 3; i++) drive(0, 1, 1, 1, 0);
        // Event and ack coincide in HOLD.
        drive(0, 1, 0, 0, 0);
        drive(0, 1, 1, 1, 0);
        drive(0, 1, 1, 1, 1);
        for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, 0);
        // Saturation: 300 stop pulses with ack held.
        for (int i = 0; i < 300; i++) begin
            drive(0, 1, 1, 0, 1);
            drive(0, 1, 0, 0, 1);
        end
        for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, 0);
        // en=0: pulses lost, timestamp frozen, failure_o still follows.
        for (int i = 0; i < 6; i++) drive(0, 0, i[0], 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, 0);
        // Reset in HOLD.
        drive(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 1, 0, 1, 0);
        drive(1, 1, 1, 1, 0);
        for (int i = 0; i < 20; i++) drive(0, 1, 0, 0, 0);
        // Random traffic.
        s = 0; u = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) s = ~s;
            if ($urandom_range(0, 5) == 0) u = ~u;
            drive($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0,
                  s, u, $urandom_range(0, 4) == 0);
        end
        drive(0, 1, 0, 0, 0);
        n_cmp++;
        if (expq.size() != 0 || n_pushed != n_cmp - 1) begin
            n_bad++;
            $display("FAIL drain left=%0d pushed=%0d checked=%0d", expq.size(), n_pushed, n_cmp - 1);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/assert_fail_capture.md
Name: assert_fail_capture

Overview:
- Consumes the per-source assertion conditions that are ORed into the emulation FAILURE net: the `stop` request and the `ucf` (unconditional failure) flag.
- Registers and edge-detects each source, timestamps the first failure, counts all failures and raises a halt request to the host/runtime.
- Holds the halt request until the host acknowledges it, then re-arms once both sources are quiet.
- Sits directly downstream of the assertion OR stage in the emulation top.

Parameters:
TS_W, 32, width of free-running cycle timestamp counter
CNT_W, 8, width of saturating failure counter

Ports:
clk  input  1  design clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
en  input  1  monitoring enable; 0 freezes detection and timestamp
stop_in  input  1  stop assertion source (level)
ucf_in  input  1  unconditional-failure source (level)
failure_o  output  1  registered OR of sampled sources (stop_q | ucf_q)
halt_req  output  1  halt request to host; high from capture until ack
host_ack  input  1  host acknowledge; single-cycle pulse or level
fail_src  output  2  captured source bits {ucf,stop} of first failure
fail_time  output  TS_W  cycle_cnt value at the captured event
fail_count  output  CNT_W  failures seen since reset (saturating)
fail_ovf  output  1  a failure edge occurred while a record was held
cycle_cnt  output  TS_W  free-running timestamp

Behaviour:
Reset:
- rst=1 at an edge clears all flops: every output is 0 and the FSM goes to IDLE.
- Reset overrides everything, including mid-HOLD/DRAIN and a simultaneous event.

Sampling and edge detection:
- stop_in/ucf_in are registered into stop_q/ucf_q, then into stop_qq/ucf_qq.
- edge[0] = stop_q & ~stop_qq; edge[1] = ucf_q & ~ucf_qq; ev = en & |edge.
- failure_o = stop_q | ucf_q, independent of en.

Timestamp:
- cycle_cnt increments by 1 each cycle with en=1 and wraps from all-ones to 0.
- Held while en=0.

Counter:
- On each cycle with ev=1, fail_count += 1, saturating at 2^CNT_W-1.
- A cycle where both edges are set counts once.
- Counting happens in every FSM state.

FSM (IDLE, HOLD, DRAIN):
- IDLE, ev=1:
  - next state HOLD; fail_src <= edge; fail_time <= current cycle_cnt; halt_req <= 1; fail_ovf <= 0.
  - Latency: a source first high before edge k gives stop_q high after k, and halt_req high after k+1.
- IDLE, host_ack: ignored.
- HOLD:
  - halt_req stays 1; fail_src and fail_time are frozen.
  - ev=1 sets fail_ovf (sticky until the next capture or reset).
  - host_ack=1: halt_req <= 0. Go to DRAIN if stop_q|ucf_q, else IDLE.
  - ev and host_ack in the same cycle: ack is taken, ovf is set, the count is incremented, and the event is not captured.
- DRAIN:
  - Wait until stop_q=0 and ucf_q=0, then go to IDLE.
  - Edges in DRAIN set fail_ovf and count, but are not captured.

Record retention:
- fail_src and fail_time keep their last values after release, until the next capture in IDLE.
- The event that releases DRAIN is evaluated only in the following IDLE cycle.

en=0:
- No ev and no counting; the FSM holds its state.
- host_ack is still honoured in HOLD.
- Edges of sources that rose while en=0 are lost: the sampling flops keep running.

Test Plan:
- Reset then stop_in rises with cycle_cnt=5 when stop_q first seen -> after 2 clocks: halt_req=1, fail_src=01, fail_time=5, fail_count=1, failure_o=1.
- stop_in and ucf_in rise in the same cycle -> fail_src=11, fail_count=1 (not 2).
- In HOLD, ucf_in rises -> fail_ovf=1, fail_count=2, fail_src unchanged. Then host_ack while stop_in still high -> halt_req=0, DRAIN. Drop stop_in -> IDLE. New stop edge -> fresh capture with fail_ovf=0, fail_count=3.
- Toggle stop_in 300 times with CNT_W=8 -> fail_count saturates at 255.
- en=0 while stop_in pulses -> no halt_req, cycle_cnt frozen, fail_count unchanged, failure_o follows the input.
- Assert rst during HOLD with halt_req=1 -> next cycle all outputs 0 and IDLE. cycle_cnt preset near all-ones (TS_W=4 bench) wraps 15->0.
